// File: rtl/eth_tx_pkg.sv
// Shared types, constants and CRC helpers for the MII transmit frame sequencer.
package eth_tx_pkg;

  localparam int unsigned PREAMBLE_NIBBLES = 15;
  localparam int unsigned IFG_NIBBLES      = 24;
  localparam int unsigned MIN_BYTES        = 60;
  localparam int unsigned FCS_NIBBLES      = 8;
  localparam int unsigned BYTE_CNT_W       = 11;
  localparam int unsigned CNT_W            =
    $clog2(((PREAMBLE_NIBBLES > IFG_NIBBLES) ? PREAMBLE_NIBBLES : IFG_NIBBLES) + 1);

  localparam logic [3:0]  SFD_NIBBLE = 4'hD;
  localparam logic [3:0]  PRE_NIBBLE = 4'h5;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  // IEEE 802.3 CRC-32 generator x^32+x^26+...+1, MSB-first form
  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_IFG
  } state_t;

  // Shift one wire nibble (bit 0 first) into the MSB-first CRC register.
  function automatic logic [31:0] crc_nibble_step(input logic [31:0] crc,
                                                  input logic [3:0]  nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[31] ^ nib[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Complemented FCS nibble k, highest CRC bit goes out first on txd[0].
  function automatic logic [3:0] fcs_nibble(input logic [31:0] crc,
                                            input logic [2:0]  k);
    logic [31:0] s;
    s = crc << {k, 2'b00};
    return ~{s[28], s[29], s[30], s[31]};
  endfunction

endpackage

// File: rtl/mii_fcs_nibble.sv
// CRC-32 nibble engine: register with sync reset/clear to all ones and enable.
module mii_fcs_nibble
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next_c
);

  logic [31:0] crc;

  always_comb begin
    crc_next_c = crc;
    if (clr)     crc_next_c = CRC_INIT;
    else if (en) crc_next_c = crc_nibble_step(crc, nib);
  end

  always_ff @(posedge clk) begin
    if (rst) crc <= CRC_INIT;
    else     crc <= crc_next_c;
  end

endmodule

// File: rtl/mii_tx_frame_ctrl.sv
// MII TX frame sequencer: preamble, SFD, payload, optional pad, FCS and IFG.
// Define ETH_TX_PAD_EN to zero-pad short frames to MIN_BYTES before the FCS.
module mii_tx_frame_ctrl
  import eth_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       underrun
);

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic [7:0]            byte_q, byte_d;
  logic                  last_q, last_d;

  logic [3:0]  txd_d;
  logic        tx_en_d, tx_er_d, s_ready_d, busy_d, underrun_d;
  logic        crc_clr, crc_en;
  logic [31:0] crc_next;

  // The engine consumes the nibble currently on txd, so FCS nibbles read its next value.
  assign crc_clr = (state == ST_PRE);
  assign crc_en  = (state == ST_DATA_LO) || (state == ST_DATA_HI) || (state == ST_PAD);

  mii_fcs_nibble u_fcs (
    .clk        (clk),
    .rst        (rst),
    .clr        (crc_clr),
    .en         (crc_en),
    .nib        (txd),
    .crc_next_c (crc_next)
  );

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    byte_cnt_d = byte_cnt;
    byte_d     = byte_q;
    last_d     = last_q;
    txd_d      = 4'h0;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    s_ready_d  = 1'b0;
    underrun_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s_valid) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (cnt == CNT_W'(PREAMBLE_NIBBLES - 1)) state_d = ST_SFD;
        else                                      cnt_d   = cnt + 1'b1;
      end
      ST_SFD: begin
        if (s_valid) begin
          byte_d     = s_data;
          last_d     = s_last;
          byte_cnt_d = BYTE_CNT_W'(1);
          state_d    = ST_DATA_LO;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_DATA_LO: state_d = ST_DATA_HI;
      ST_DATA_HI: begin
        if (last_q) begin
          state_d = ST_FCS;
          cnt_d   = '0;
`ifdef ETH_TX_PAD_EN
          if (byte_cnt < BYTE_CNT_W'(MIN_BYTES)) state_d = ST_PAD;
`endif
        end else if (s_valid) begin
          byte_d  = s_data;
          last_d  = s_last;
          state_d = ST_DATA_LO;
          if (byte_cnt != '1) byte_cnt_d = byte_cnt + 1'b1;
        end else begin
          state_d = ST_ABORT;
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        // cnt[0] selects the low/high nibble of the current zero byte
        cnt_d = cnt + 1'b1;
        if (cnt[0]) begin
          byte_cnt_d = byte_cnt + 1'b1;
          if (byte_cnt == BYTE_CNT_W'(MIN_BYTES - 1)) begin
            state_d = ST_FCS;
            cnt_d   = '0;
          end
        end
      end
`endif
      ST_FCS: begin
        if (cnt == CNT_W'(FCS_NIBBLES - 1)) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_ABORT: begin
        state_d = ST_IFG;
        cnt_d   = '0;
      end
      ST_IFG: begin
        // Last gap cycle doubles as the IDLE decision so back-to-back spacing is exactly the gap.
        if (cnt == CNT_W'(IFG_NIBBLES - 1)) begin
          cnt_d   = '0;
          state_d = s_valid ? ST_PRE : ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output decode of the upcoming state, registered alongside it.
    case (state_d)
      ST_PRE: begin
        txd_d   = PRE_NIBBLE;
        tx_en_d = 1'b1;
      end
      ST_SFD: begin
        txd_d     = SFD_NIBBLE;
        tx_en_d   = 1'b1;
        s_ready_d = 1'b1;
      end
      ST_DATA_LO: begin
        txd_d   = byte_d[3:0];
        tx_en_d = 1'b1;
      end
      ST_DATA_HI: begin
        txd_d     = byte_d[7:4];
        tx_en_d   = 1'b1;
        s_ready_d = ~last_d;
      end
      ST_PAD:  tx_en_d = 1'b1;
      ST_FCS: begin
        txd_d   = fcs_nibble(crc_next, cnt_d[2:0]);
        tx_en_d = 1'b1;
      end
      ST_ABORT: begin
        tx_en_d    = 1'b1;
        tx_er_d    = 1'b1;
        underrun_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      byte_cnt <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      txd      <= 4'h0;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      byte_cnt <= byte_cnt_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      txd      <= txd_d;
      tx_en    <= tx_en_d;
      tx_er    <= tx_er_d;
      s_ready  <= s_ready_d;
      busy     <= busy_d;
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_mii_tx_frame_ctrl.sv
// Directed self-checking bench for mii_tx_frame_ctrl (follows ETH_TX_PAD_EN if defined).
module tb_mii_tx_frame_ctrl;

  typedef logic [7:0] bq_t [$];
  typedef int         iq_t [$];
  typedef logic [3:0] nq_t [$];
  typedef struct packed {
    logic       en;
    logic       er;
    logic       ur;
    logic       rdy;
    logic       bsy;
    logic [3:0] d;
  } smp_t;

`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int PRE_N = 15;
  localparam int IFG_N = 24;
  localparam int MIN_N = 60;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_last;
  logic [7:0] s_data;
  logic       s_ready, tx_en, tx_er, busy, underrun;
  logic [3:0] txd;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   run_pos = 0;
  smp_t log_q[$];
  int   starts[$];
  int   lens[$];

  mii_tx_frame_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .txd      (txd),
    .tx_en    (tx_en),
    .tx_er    (tx_er),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    log_q.push_back({tx_en, tx_er, underrun, s_ready, busy, txd});
    run_pos = tx_en ? run_pos + 1 : 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-wise reflected CRC-32 reference, result already complemented.
  function automatic logic [31:0] golden_fcs(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic nq_t build_exp(input bq_t b);
    nq_t         q;
    bq_t         p;
    logic [31:0] f;
    p = b;
    if (PAD) while (p.size() < MIN_N) p.push_back(8'h00);
    for (int i = 0; i < PRE_N; i++) q.push_back(4'h5);
    q.push_back(4'hD);
    foreach (p[i]) begin
      q.push_back(p[i][3:0]);
      q.push_back(p[i][7:4]);
    end
    f = golden_fcs(p);
    for (int k = 0; k < 8; k++) q.push_back(f[4*k +: 4]);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams bytes; frames split by lens; s_valid drops after drop_after accepts (0 = never).
  task automatic send_frames(input bq_t data, input iq_t lens_in, input int drop_after);
    int idx, fi, bound, guard;
    bit acc;
    idx = 0; fi = 0; guard = 0;
    bound   = lens_in[0];
    s_valid = 1'b1;
    s_data  = data[0];
    s_last  = (bound == 1);
    while (idx < data.size() && guard < 5000) begin
      @(negedge clk);
      acc = s_ready && s_valid;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (idx == drop_after) begin
          s_valid = 1'b0;
          s_last  = 1'b0;
          break;
        end
        if (idx == bound && fi + 1 < lens_in.size()) begin
          fi++;
          bound += lens_in[fi];
        end
        if (idx < data.size()) begin
          s_data = data[idx];
          s_last = (idx == bound - 1);
        end else begin
          s_valid = 1'b0;
          s_last  = 1'b0;
          s_data  = 8'h00;
        end
      end
    end
    if (guard >= 5000) check_eq("send_timeout", guard, 0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || tx_en) && g < 1000);
    if (g >= 1000) check_eq("idle_timeout", g, 0);
    step();
  endtask

  task automatic find_runs();
    starts.delete();
    lens.delete();
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].en && (i == 0 || !log_q[i-1].en)) begin
        starts.push_back(i);
        lens.push_back(0);
      end
      if (log_q[i].en) lens[lens.size()-1] = lens[lens.size()-1] + 1;
    end
  endtask

  function automatic int ifg_len(input int r);
    int n;
    n = 0;
    for (int i = starts[r] + lens[r]; i < log_q.size(); i++) begin
      if (log_q[i].en || !log_q[i].bsy) break;
      n++;
    end
    return n;
  endfunction

  task automatic check_frame(input string tag, input int r, input nq_t exp);
    int f0, ers;
    if (r >= starts.size()) begin
      check_eq({tag, "_present"}, starts.size(), r + 1);
      return;
    end
    check_eq({tag, "_len"}, lens[r], exp.size());
    f0 = n_fail;
    ers = 0;
    for (int i = 0; i < exp.size() && i < lens[r] && n_fail == f0; i++)
      check_eq($sformatf("%s_nib%0d", tag, i), log_q[starts[r] + i].d, exp[i]);
    for (int i = 0; i < lens[r]; i++) if (log_q[starts[r] + i].er) ers++;
    check_eq({tag, "_tx_er"}, ers, 0);
  endtask

  initial begin
    bq_t         d;
    iq_t         l;
    nq_t         e;
    int          cnt, g, target, neff;
    logic [3:0]  hard_fcs [8];

    hard_fcs = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_txd", txd, 0);
    check_eq("rst_tx_en", tx_en, 0);
    check_eq("rst_tx_er", tx_er, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_underrun", underrun, 0);
    step();

    // Upstream silent in IDLE for 10 cycles
    log_q.delete();
    repeat (10) step();
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].en || log_q[i].rdy || log_q[i].bsy) cnt++;
    check_eq("idle_activity", cnt, 0);

    // "123456789"
    d.delete(); l.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'(8'h31 + i));
    l.push_back(9);
    log_q.delete();
    send_frames(d, l, 0);
    wait_idle();
    find_runs();
    e = build_exp(d);
    check_eq("f1_runs", starts.size(), 1);
    if (starts.size() > 0) begin
      check_eq("f1_start", starts[0], 1);
      check_eq("f1_len_hand", lens[0], PAD ? 144 : 42);
      check_frame("f1", 0, e);
      for (int k = 0; k < 8; k++)
        check_eq($sformatf("f1_fcs_hand%0d", k), log_q[starts[0] + lens[0] - 8 + k].d,
                 PAD ? e[e.size() - 8 + k] : hard_fcs[k]);
      check_eq("f1_ifg", ifg_len(0), IFG_N);
    end

    // One-byte payload 0xA5
    d.delete(); l.delete();
    d.push_back(8'hA5);
    l.push_back(1);
    log_q.delete();
    send_frames(d, l, 0);
    wait_idle();
    find_runs();
    check_eq("f2_runs", starts.size(), 1);
    check_eq("f2_len_hand", (starts.size() > 0) ? lens[0] : 0, PAD ? 144 : 26);
    check_frame("f2", 0, build_exp(d));

    // s_valid dropped after byte 3
    d.delete(); l.delete();
    for (int i = 0; i < 10; i++) d.push_back(8'(8'h10 + i));
    l.push_back(10);
    log_q.delete();
    send_frames(d, l, 3);
    wait_idle();
    find_runs();
    check_eq("ab_runs", starts.size(), 1);
    if (starts.size() > 0) begin
      check_eq("ab_len", lens[0], PRE_N + 1 + 6 + 1);
      e = build_exp(d);
      g = n_fail;
      for (int i = 0; i < PRE_N + 1 + 6 && n_fail == g; i++)
        check_eq($sformatf("ab_nib%0d", i), log_q[starts[0] + i].d, e[i]);
      cnt = starts[0] + lens[0] - 1;
      check_eq("ab_er", log_q[cnt].er, 1);
      check_eq("ab_underrun", log_q[cnt].ur, 1);
      check_eq("ab_txd", log_q[cnt].d, 0);
      check_eq("ab_ifg", ifg_len(0), IFG_N);
    end
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].ur) cnt++;
    check_eq("ab_underrun_pulses", cnt, 1);

    // Back-to-back with s_valid held high
    d.delete(); l.delete();
    d.push_back(8'hDE); d.push_back(8'hAD); d.push_back(8'hBE); d.push_back(8'hEF);
    d.push_back(8'h01); d.push_back(8'h02); d.push_back(8'h03);
    l.push_back(4); l.push_back(3);
    log_q.delete();
    send_frames(d, l, 0);
    wait_idle();
    find_runs();
    check_eq("b2b_runs", starts.size(), 2);
    if (starts.size() == 2) begin
      bq_t d1, d2;
      for (int i = 0; i < 4; i++) d1.push_back(d[i]);
      for (int i = 4; i < 7; i++) d2.push_back(d[i]);
      check_eq("b2b_gap", starts[1] - (starts[0] + lens[0]), IFG_N);
      check_frame("b2b_a", 0, build_exp(d1));
      check_frame("b2b_b", 1, build_exp(d2));
    end

    // Reset during FCS nibble 3, then a clean frame
    d.delete(); l.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'(8'h31 + i));
    l.push_back(9);
    e = build_exp(d);
    neff = PAD ? MIN_N : 9;
    target = PRE_N + 1 + 2 * neff + 4;
    log_q.delete();
    send_frames(d, l, 0);
    g = 0;
    while (run_pos != target && g < 500) begin
      @(negedge clk);
      #1;
      g++;
    end
    check_eq("rst_reach_fcs3", run_pos, target);
    check_eq("rst_fcs3_nib", txd, e[target - 1]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_txd", txd, 0);
    check_eq("mid_rst_tx_en", tx_en, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_tx_er", tx_er, 0);
    check_eq("mid_rst_underrun", underrun, 0);
    step();

    d.delete(); l.delete();
    d.push_back(8'h10); d.push_back(8'h20); d.push_back(8'h30);
    l.push_back(3);
    log_q.delete();
    send_frames(d, l, 0);
    wait_idle();
    find_runs();
    check_eq("post_rst_runs", starts.size(), 1);
    check_frame("post_rst", 0, build_exp(d));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
